// File: rtl/seg595_pkg.sv
// Shared constants, frame field positions, control states and select-decode
// helpers for the 74HC595 stream receiver.
package seg595_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int NUM_DIGITS      = 8;
  localparam int TIMEOUT_CYC_12M = 120000;

  // Field positions inside one latched word.
  localparam int SEG_MSB = 15;
  localparam int SEG_LSB = 8;
  localparam int SEL_MSB = 7;
  localparam int SEL_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_e;

  // True when the active-low digit select has exactly one 0 bit.
  function automatic logic sel_is_onehot0(input logic [7:0] sel);
    int unsigned zeros;
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (!sel[i]) begin
        zeros = zeros + 1;
      end else begin
        zeros = zeros;
      end
    end
    return (zeros == 1);
  endfunction

  // Position of the 0 bit in the select field; only meaningful when the
  // select is one-hot-zero.
  function automatic logic [2:0] sel_index(input logic [7:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!sel[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg595_frame_rx_edge_sync.sv
// Multi-stage synchronizer for one tapped bus line with rise/fall detection.
// The synchronized level carries the same delay as the edge strobes, so a data
// line passed through its own instance stays aligned with the clock line.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one delayed copy of its output for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/seg595_frame_rx.sv
// Passive receiver for the 595 display stream: rebuilds each latched word,
// validates it, keeps a shadow of all digit segment codes, tracks scan
// completion and link liveness.
module seg595_frame_rx
  import seg595_pkg::*;
#(
  parameter int FRAME_BITS  = seg595_pkg::FRAME_BITS,
  parameter int NUM_DIGITS  = seg595_pkg::NUM_DIGITS,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = seg595_pkg::TIMEOUT_CYC_12M
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seg_sck_in,
  input  logic                    seg_rck_in,
  input  logic                    seg_din_in,
  output logic                    word_valid,
  output logic [FRAME_BITS-1:0]   word_data,
  output logic [7:0]              seg_code,
  output logic [2:0]              digit_idx,
  output logic                    frame_err,
  output logic                    scan_done,
  output logic [8*NUM_DIGITS-1:0] disp_mem,
  output logic                    link_alive
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

  logic sck_rise_s, rck_rise_s, din_s;
  logic sck_lvl_s, sck_fall_s, rck_lvl_s, rck_fall_s, din_rise_s, din_fall_s;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d_i(seg_sck_in),
    .level_o(sck_lvl_s), .rise_o(sck_rise_s), .fall_o(sck_fall_s)
  );
  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_rck (
    .clk(clk), .rst_n(rst_n), .d_i(seg_rck_in),
    .level_o(rck_lvl_s), .rise_o(rck_rise_s), .fall_o(rck_fall_s)
  );
  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .d_i(seg_din_in),
    .level_o(din_s), .rise_o(din_rise_s), .fall_o(din_fall_s)
  );

  rx_state_e                state_q, state_d;
  logic [FRAME_BITS-1:0]    shreg_q, shreg_d;
  logic [4:0]               bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]    word_data_q, word_data_d;
  logic [7:0]               seg_code_q, seg_code_d;
  logic [2:0]               digit_idx_q, digit_idx_d;
  logic [8*NUM_DIGITS-1:0]  disp_mem_q, disp_mem_d;
  logic [NUM_DIGITS-1:0]    scan_mask_q, scan_mask_d;
  logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                     link_alive_q, link_alive_d;
  logic                     word_valid_q, word_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     scan_done_q, scan_done_d;

  logic                     frame_ok_s;
  logic [2:0]               idx_s;
  logic [NUM_DIGITS-1:0]    mask_set_s;

  // The latch judges the word as it stood before any coincident shift.
  assign frame_ok_s = (bit_cnt_q == 5'(FRAME_BITS)) &&
                      sel_is_onehot0(shreg_q[SEL_MSB:SEL_LSB]);
  assign idx_s      = sel_index(shreg_q[SEL_MSB:SEL_LSB]);
  assign mask_set_s = scan_mask_q | (NUM_DIGITS'(1) << idx_s);

  // Control state: SHIFT while bits arrive, CHECK for the cycle the result pulses.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rck_rise_s) begin
          state_d = ST_CHECK;
        end else if (sck_rise_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rck_rise_s) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: shifting, latch evaluation, shadow memory, scan and timeout.
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    word_data_d  = word_data_q;
    seg_code_d   = seg_code_q;
    digit_idx_d  = digit_idx_q;
    disp_mem_d   = disp_mem_q;
    scan_mask_d  = scan_mask_q;
    tmo_cnt_d    = tmo_cnt_q;
    link_alive_d = link_alive_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    scan_done_d  = 1'b0;

    if (sck_rise_s) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], din_s};
      if (bit_cnt_q != 5'd31) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      shreg_d = shreg_q;
    end

    // A coincident shift becomes bit 1 of the next frame.
    if (rck_rise_s) begin
      bit_cnt_d = sck_rise_s ? 5'd1 : 5'd0;
    end else begin
      bit_cnt_d = bit_cnt_d;
    end

    if (rck_rise_s && frame_ok_s) begin
      word_data_d  = shreg_q;
      seg_code_d   = shreg_q[SEG_MSB:SEG_LSB];
      digit_idx_d  = idx_s;
      disp_mem_d[{idx_s, 3'b000} +: 8] = shreg_q[SEG_MSB:SEG_LSB];
      word_valid_d = 1'b1;
      tmo_cnt_d    = {TMO_W{1'b0}};
      link_alive_d = 1'b1;
      if (&mask_set_s) begin
        scan_done_d = 1'b1;
        scan_mask_d = {NUM_DIGITS{1'b0}};
      end else begin
        scan_mask_d = mask_set_s;
      end
    end else begin
      frame_err_d = rck_rise_s;
      if (tmo_cnt_q != TMO_MAX) begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end else begin
        tmo_cnt_d = tmo_cnt_q;
      end
      if (tmo_cnt_d == TMO_MAX) begin
        link_alive_d = 1'b0;
      end else begin
        link_alive_d = link_alive_q;
      end
    end
  end

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= {FRAME_BITS{1'b0}};
      bit_cnt_q    <= 5'd0;
      word_data_q  <= {FRAME_BITS{1'b0}};
      seg_code_q   <= 8'd0;
      digit_idx_q  <= 3'd0;
      disp_mem_q   <= {(8*NUM_DIGITS){1'b0}};
      scan_mask_q  <= {NUM_DIGITS{1'b0}};
      tmo_cnt_q    <= {TMO_W{1'b0}};
      link_alive_q <= 1'b0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      scan_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_data_q  <= word_data_d;
      seg_code_q   <= seg_code_d;
      digit_idx_q  <= digit_idx_d;
      disp_mem_q   <= disp_mem_d;
      scan_mask_q  <= scan_mask_d;
      tmo_cnt_q    <= tmo_cnt_d;
      link_alive_q <= link_alive_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      scan_done_q  <= scan_done_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign seg_code   = seg_code_q;
  assign digit_idx  = digit_idx_q;
  assign frame_err  = frame_err_q;
  assign scan_done  = scan_done_q;
  assign disp_mem   = disp_mem_q;
  assign link_alive = link_alive_q;

endmodule
